// File: rtl/game_timer_if.sv
// Strobe inputs and BCD/status outputs of the match clock, grouped for
// the debounced-button side (master) and the timer core (slave).
interface game_timer_if;
  logic       START;
  logic       PAUSE;
  logic       LOAD;
  logic [6:0] LOAD_MIN;
  logic [3:0] MIN_T;
  logic [3:0] MIN_O;
  logic [3:0] SEC_T;
  logic [3:0] SEC_O;
  logic       RUNNING;
  logic       TICK;
  logic       EXPIRED;

  modport master (
    output START, PAUSE, LOAD, LOAD_MIN,
    input  MIN_T, MIN_O, SEC_T, SEC_O, RUNNING, TICK, EXPIRED
  );

  modport slave (
    input  START, PAUSE, LOAD, LOAD_MIN,
    output MIN_T, MIN_O, SEC_T, SEC_O, RUNNING, TICK, EXPIRED
  );
endinterface

// File: rtl/game_timer.sv
// MM:SS countdown match clock with an internal one-second prescaler,
// BCD digit outputs and registered RUNNING/TICK/EXPIRED status.
module game_timer #(
  parameter int DIV       = 50_000_000,
  parameter int START_MIN = 10
) (
  input  logic CLK_50MHZ,
  input  logic RST,
  game_timer_if.slave bus
);
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } digits_t;

  localparam digits_t RST_DIG = {4'(START_MIN / 10), 4'(START_MIN % 10), 8'h00};

  state_t        state, state_n;
  logic [PW-1:0] cnt, cnt_n;
  digits_t       dig, dig_n, dec, load_dig;
  logic          run_q, run_n, tick_q, tick_n, exp_q, exp_n;
  logic [6:0]    lm;
  logic          wrap;

  assign lm       = (bus.LOAD_MIN > 7'd99) ? 7'd99 : bus.LOAD_MIN;
  assign load_dig = {4'(lm / 7'd10), 4'(lm % 7'd10), 8'h00};
  assign wrap     = (state == RUN) && (cnt == PW'(DIV - 1));

  // Borrow chain; never evaluated at 00:00 because RUN requires a nonzero count.
  always_comb begin
    dec = dig;
    if (dig.so != 4'd0) dec.so = dig.so - 4'd1;
    else begin
      dec.so = 4'd9;
      if (dig.st != 4'd0) dec.st = dig.st - 4'd1;
      else begin
        dec.st = 4'd5;
        if (dig.mo != 4'd0) dec.mo = dig.mo - 4'd1;
        else begin
          dec.mo = 4'd9;
          dec.mt = dig.mt - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dig_n   = dig;
    tick_n  = 1'b0;
    exp_n   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.LOAD) begin
          dig_n = load_dig;
          cnt_n = '0;
        end else if (bus.START && dig != '0) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_n  = '0;
          dig_n  = dec;
          tick_n = 1'b1;
          // Expiry takes precedence over a coincident pause.
          if (dec == '0) begin
            state_n = DONE;
            exp_n   = 1'b1;
          end else if (bus.PAUSE) begin
            state_n = PAUSED;
          end
        end else begin
          cnt_n = cnt + PW'(1);
          if (bus.PAUSE) state_n = PAUSED;
        end
      end
      PAUSED: begin
        if (bus.LOAD) begin
          dig_n   = load_dig;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (bus.PAUSE || bus.START) begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (bus.LOAD) begin
          dig_n   = load_dig;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    run_n = (state_n == RUN);
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      dig    <= RST_DIG;
      run_q  <= 1'b0;
      tick_q <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dig    <= dig_n;
      run_q  <= run_n;
      tick_q <= tick_n;
      exp_q  <= exp_n;
    end
  end

  assign bus.MIN_T   = dig.mt;
  assign bus.MIN_O   = dig.mo;
  assign bus.SEC_T   = dig.st;
  assign bus.SEC_O   = dig.so;
  assign bus.RUNNING = run_q;
  assign bus.TICK    = tick_q;
  assign bus.EXPIRED = exp_q;
endmodule
